// File: rtl/mnist_pkg.sv
// Shared constants, state encoding and window-element mapping for the MNIST conv front end.
package mnist_pkg;

  localparam int unsigned IMG_W     = 28;
  localparam int unsigned IMG_H     = 28;
  localparam int unsigned PIX_W     = 8;
  localparam int unsigned WIN_DIM   = 3;
  localparam int unsigned WIN_COUNT = (IMG_H - 2) * (IMG_W - 2);
  localparam int unsigned CNT_W     = 5;

  typedef enum logic [1:0] {
    StFill,
    StStream,
    StDone
  } win_state_e;

  // Element k of a packed window sits at row k/3, col k%3.
  function automatic int unsigned win_idx(input int unsigned row, input int unsigned col);
    return row * WIN_DIM + col;
  endfunction

endpackage

// File: rtl/mnist_line_buffer.sv
// One image row of delay: a Depth-deep shift register advanced only when en is high.
module mnist_line_buffer #(
  parameter int unsigned Depth = 28,
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             en,
  input  logic [Width-1:0] din,
  output logic [Width-1:0] dout
);

  logic [Width-1:0] mem_q [Depth];

  // No reset: every entry is overwritten during frame fill before it is read.
  always_ff @(posedge clk) begin
    if (en) begin
      mem_q[0] <= din;
      for (int unsigned i = 1; i < Depth; i++) begin
        mem_q[i] <= mem_q[i-1];
      end
    end
  end

  assign dout = mem_q[Depth-1];

endmodule

// File: rtl/mnist_window_gen.sv
// Turns a raster 28x28 pixel stream into 3x3 conv windows, one frame per reset.
// Optional drop counter enabled by defining MNIST_WIN_DROP_CNT_EN.
module mnist_window_gen
  import mnist_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  logic [PIX_W-1:0]               in_pixel,
  output logic                           in_ready,
  output logic                           win_valid,
  output logic [WIN_DIM*WIN_DIM*PIX_W-1:0] win_data,
  output logic [CNT_W-1:0]               win_row,
  output logic [CNT_W-1:0]               win_col,
  output logic                           frame_done
`ifdef MNIST_WIN_DROP_CNT_EN
  ,
  output logic [9:0]                     drop_cnt
`endif
);

  localparam logic [CNT_W-1:0] LastCol = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] LastRow = CNT_W'(IMG_H - 1);
  localparam logic [CNT_W-1:0] Two     = CNT_W'(2);
  localparam logic [CNT_W-1:0] One     = CNT_W'(1);

  win_state_e state_q, state_d;
  logic [CNT_W-1:0] col_q, row_q;
  logic accept, shift, emit, last_pix;
  logic [PIX_W-1:0] lb0_out, lb1_out;
  logic [PIX_W-1:0] win_q [WIN_DIM][WIN_DIM];
  logic [PIX_W-1:0] win_d [WIN_DIM][WIN_DIM];
  logic [WIN_DIM*WIN_DIM*PIX_W-1:0] win_flat;

  logic                           win_valid_q, frame_done_q;
  logic [WIN_DIM*WIN_DIM*PIX_W-1:0] win_data_q;
  logic [CNT_W-1:0]               win_row_q, win_col_q;

  assign accept   = in_valid & in_ready;
  assign shift    = accept & ~rst;
  assign emit     = accept && (row_q >= Two) && (col_q >= Two);
  assign last_pix = (row_q == LastRow) && (col_q == LastCol);

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= StFill;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFill:   if (accept && row_q == Two && col_q == Two) state_d = StStream;
      StStream: if (accept && last_pix) state_d = StDone;
      StDone:   state_d = StDone;
      default:  state_d = StFill;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready = 1'b1;
    if (state_q == StDone) in_ready = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else if (accept) begin
      if (col_q == LastCol) begin
        col_q <= '0;
        row_q <= (row_q == LastRow) ? '0 : row_q + One;
      end else begin
        col_q <= col_q + One;
      end
    end
  end

  mnist_line_buffer #(
    .Depth (IMG_W),
    .Width (PIX_W)
  ) u_lb0 (
    .clk  (clk),
    .en   (shift),
    .din  (in_pixel),
    .dout (lb0_out)
  );

  mnist_line_buffer #(
    .Depth (IMG_W),
    .Width (PIX_W)
  ) u_lb1 (
    .clk  (clk),
    .en   (shift),
    .din  (lb0_out),
    .dout (lb1_out)
  );

  // Window slides left; new right column is {two rows up, one row up, current}.
  always_comb begin
    for (int unsigned r = 0; r < WIN_DIM; r++) begin
      win_d[r][0] = win_q[r][1];
      win_d[r][1] = win_q[r][2];
    end
    win_d[0][2] = lb1_out;
    win_d[1][2] = lb0_out;
    win_d[2][2] = in_pixel;
  end

  always_comb begin
    win_flat = '0;
    for (int unsigned r = 0; r < WIN_DIM; r++) begin
      for (int unsigned c = 0; c < WIN_DIM; c++) begin
        win_flat[win_idx(r, c)*PIX_W +: PIX_W] = win_d[r][c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (shift) win_q <= win_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      win_data_q   <= '0;
      win_row_q    <= '0;
      win_col_q    <= '0;
    end else begin
      win_valid_q  <= emit;
      frame_done_q <= emit && last_pix;
      if (emit) begin
        win_data_q <= win_flat;
        win_row_q  <= row_q - Two;
        win_col_q  <= col_q - Two;
      end
    end
  end

  assign win_valid  = win_valid_q;
  assign win_data   = win_data_q;
  assign win_row    = win_row_q;
  assign win_col    = win_col_q;
  assign frame_done = frame_done_q;

`ifdef MNIST_WIN_DROP_CNT_EN
  logic [9:0] drop_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_q <= '0;
    end else if (in_valid && !in_ready && drop_q != 10'h3FF) begin
      drop_q <= drop_q + 10'd1;
    end
  end

  assign drop_cnt = drop_q;
`endif

endmodule
